// File: rtl/matrix_chunk_loader.sv
// matrix_chunk_loader: fetches BANDWIDTH consecutive words from a 1-cycle
// latency single-port weight SRAM, packs them into a wide bus for the
// matrix-vector multiplier and holds them stable while matrix_ready is high.
// Optional perf counters are compiled in with `define MATRIX_CHUNK_LOADER_PERF_EN.
module matrix_chunk_loader #(
   parameter int MAX_ROWS   = 64,
   parameter int MAX_COLS   = 64,
   parameter int BANDWIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   localparam int ADDR_W    = $clog2(MAX_ROWS*MAX_COLS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            matrix_enable,
   input  logic [ADDR_W-1:0]               matrix_addr,
   output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
   output logic                            matrix_ready,
   output logic                            sram_en,
   output logic [ADDR_W-1:0]               sram_addr,
   input  logic [DATA_WIDTH-1:0]           sram_rdata
`ifdef MATRIX_CHUNK_LOADER_PERF_EN
   ,
   output logic [31:0]                     perf_chunks,
   output logic [31:0]                     perf_stall_cycles
`endif
);

   // Counters must be able to hold BANDWIDTH itself (the "all issued" value)
   localparam int CNT_W = $clog2(BANDWIDTH+1);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      FETCH = 3'b010,
      READY = 3'b100
   } state_t;

   state_t                            r_state;
   logic [ADDR_W-1:0]                 r_base;
   logic [CNT_W-1:0]                  r_issue_cnt;
   logic [CNT_W-1:0]                  r_cap_cnt;
   logic                              r_vld;
   logic                              r_ready;
   logic [DATA_WIDTH*BANDWIDTH-1:0]   r_data;

   logic                              w_sram_en;
   logic [ADDR_W-1:0]                 w_sram_addr;

   // SRAM request: strobe only while FETCH still has words to issue; address wraps
   always_comb begin
      w_sram_en   = (r_state == FETCH) && (r_issue_cnt < CNT_W'(BANDWIDTH));
      w_sram_addr = r_base + ADDR_W'(r_issue_cnt);
   end

   // Fetch FSM: issue reads, capture returning words one cycle later, hold the chunk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_issue_cnt <= '0;
         r_cap_cnt   <= '0;
         r_vld       <= 1'b0;
         r_ready     <= 1'b0;
         r_data      <= '0;
      end else begin
         // r_vld marks that sram_rdata carries the word requested last cycle
         r_vld <= w_sram_en;
         case (r_state)
            IDLE: begin
               if (matrix_enable) begin
                  r_base      <= matrix_addr;
                  r_issue_cnt <= '0;
                  r_cap_cnt   <= '0;
                  r_state     <= FETCH;
               end
            end
            FETCH: begin
               if (!matrix_enable) begin
                  // Abort: any read still in flight is dropped because capture only happens in FETCH
                  r_state <= IDLE;
               end else begin
                  if (w_sram_en)
                     r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                  if (r_vld) begin
                     for (int i = 0; i < BANDWIDTH; i++) begin
                        if (r_cap_cnt == CNT_W'(i))
                           r_data[i*DATA_WIDTH +: DATA_WIDTH] <= sram_rdata;
                     end
                     r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                     if (r_cap_cnt == CNT_W'(BANDWIDTH-1)) begin
                        r_ready <= 1'b1;
                        r_state <= READY;
                     end
                  end
               end
            end
            READY: begin
               if (!matrix_enable) begin
                  r_ready <= 1'b0;
                  r_state <= IDLE;
               end else if (matrix_addr != r_base) begin
                  r_base      <= matrix_addr;
                  r_issue_cnt <= '0;
                  r_cap_cnt   <= '0;
                  r_ready     <= 1'b0;
                  r_state     <= FETCH;
               end
            end
            default: begin
               r_ready <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign matrix_data  = r_data;
   assign matrix_ready = r_ready;
   assign sram_en      = w_sram_en;
   assign sram_addr    = w_sram_addr;

`ifdef MATRIX_CHUNK_LOADER_PERF_EN
   logic        w_done;
   logic [31:0] r_perf_chunks;
   logic [31:0] r_perf_stall;

   // A fetch completes on the edge that captures the last lane
   always_comb begin
      w_done = (r_state == FETCH) && matrix_enable && r_vld &&
               (r_cap_cnt == CNT_W'(BANDWIDTH-1));
   end

   // Saturating counters of completed chunks and cycles the multiplier waited
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_chunks <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_done && (r_perf_chunks != 32'hFFFF_FFFF))
            r_perf_chunks <= r_perf_chunks + 32'd1;
         if (matrix_enable && !r_ready && (r_perf_stall != 32'hFFFF_FFFF))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_chunks       = r_perf_chunks;
   assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_matrix_chunk_loader.sv
// Directed testbench for matrix_chunk_loader with a 1-cycle-latency SRAM
// model holding mem[a] = a + 16'h0100.
module tb_matrix_chunk_loader;

   localparam int BW     = 16;
   localparam int DW     = 16;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              matrix_enable = 1'b0;
   logic [ADDR_W-1:0] matrix_addr = '0;
   logic [DW*BW-1:0]  matrix_data;
   logic              matrix_ready;
   logic              sram_en;
   logic [ADDR_W-1:0] sram_addr;
   logic [DW-1:0]     sram_rdata = '0;
`ifdef MATRIX_CHUNK_LOADER_PERF_EN
   logic [31:0]       perf_chunks;
   logic [31:0]       perf_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   // SRAM side bookkeeping, sampled mid-cycle when the DUT outputs are settled
   logic              en_s = 1'b0;
   logic [ADDR_W-1:0] addr_s = '0;
   int                en_count = 0;
   logic [ADDR_W-1:0] addr_log[$];

   matrix_chunk_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .matrix_enable (matrix_enable),
      .matrix_addr   (matrix_addr),
      .matrix_data   (matrix_data),
      .matrix_ready  (matrix_ready),
      .sram_en       (sram_en),
      .sram_addr     (sram_addr),
      .sram_rdata    (sram_rdata)
`ifdef MATRIX_CHUNK_LOADER_PERF_EN
      ,
      .perf_chunks       (perf_chunks),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      en_s   = sram_en;
      addr_s = sram_addr;
      if (sram_en) begin
         en_count++;
         addr_log.push_back(sram_addr);
      end
   end

   always @(posedge clk) begin
      if (en_s)
         sram_rdata <= {4'h0, addr_s} + 16'h0100;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] lane(input int i);
      return matrix_data[i*DW +: DW];
   endfunction

   // Counts edges from the request-sampling edge until ready is seen
   task automatic wait_ready(output int lat);
      int n = 0;
      do begin
         step();
         n++;
      end while (!matrix_ready && n < 60);
      lat = n - 1;
   endtask

   function automatic logic [63:0] addr_at(input int i);
      if (i < addr_log.size())
         return 64'(addr_log[i]);
      return 64'hDEAD;
   endfunction

   initial begin
      int lat;
      logic [DW*BW-1:0] saved;

      // Reset state
      #12;
      check("rst_ready", 64'(matrix_ready), 64'd0);
      check("rst_data", 64'(matrix_data[63:0]), 64'd0);
      check("rst_en", 64'(sram_en), 64'd0);
      check("rst_addr", 64'(sram_addr), 64'd0);
      step();
      rst_n = 1'b1;

      // Basic fetch at address 0
      addr_log.delete(); en_count = 0;
      matrix_enable = 1'b1; matrix_addr = 12'd0;
      wait_ready(lat);
      check("s1_latency", 64'(lat), 64'd17);
      check("s1_en_count", 64'(en_count), 64'd16);
      check("s1_addr0", addr_at(0), 64'd0);
      check("s1_addr15", addr_at(15), 64'd15);
      for (int i = 0; i < BW; i++)
         check($sformatf("s1_lane%0d", i), 64'(lane(i)), 64'(16'h0100 + i));

      // Hold in READY with the same address
      step();
      check("hold_ready", 64'(matrix_ready), 64'd1);
      check("hold_en", 64'(sram_en), 64'd0);

      // Drop enable for 5 cycles: data retained, no SRAM traffic
      saved = matrix_data;
      matrix_enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("drop_ready%0d", c), 64'(matrix_ready), 64'd0);
         check($sformatf("drop_en%0d", c), 64'(sram_en), 64'd0);
         check($sformatf("drop_data%0d", c), 64'(matrix_data == saved), 64'd1);
      end

      // Wrapping chunk at 4088
      addr_log.delete(); en_count = 0;
      matrix_enable = 1'b1; matrix_addr = 12'd4088;
      wait_ready(lat);
      check("wrap_latency", 64'(lat), 64'd17);
      check("wrap_addr7", addr_at(7), 64'd4095);
      check("wrap_addr8", addr_at(8), 64'd0);
      check("wrap_addr15", addr_at(15), 64'd7);
      check("wrap_lane0", 64'(lane(0)), 64'h10F8);
      check("wrap_lane8", 64'(lane(8)), 64'h0100);
      matrix_enable = 1'b0;
      step();

      // Abort fetch at 32 after 6 issues, then fetch 64
      addr_log.delete(); en_count = 0;
      matrix_enable = 1'b1; matrix_addr = 12'd32;
      step();
      for (int c = 0; c < 6; c++) step();
      matrix_enable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("abort_ready%0d", c), 64'(matrix_ready), 64'd0);
         check($sformatf("abort_en%0d", c), 64'(sram_en), 64'd0);
      end
      addr_log.delete(); en_count = 0;
      matrix_enable = 1'b1; matrix_addr = 12'd64;
      wait_ready(lat);
      check("refetch_latency", 64'(lat), 64'd17);
      check("refetch_en_count", 64'(en_count), 64'd16);
      check("refetch_addr0", addr_at(0), 64'd64);
      check("refetch_lane0", 64'(lane(0)), 64'h0140);
      check("refetch_lane15", 64'(lane(15)), 64'h014F);
      matrix_enable = 1'b0;
      step();

      // Fetch 16, then change address to 48 while in READY
      matrix_enable = 1'b1; matrix_addr = 12'd16;
      wait_ready(lat);
      check("a16_lane0", 64'(lane(0)), 64'h0110);
      matrix_addr = 12'd48;
      addr_log.delete(); en_count = 0;
      wait_ready(lat);
      check("a48_latency", 64'(lat), 64'd17);
      check("a48_lane0", 64'(lane(0)), 64'h0130);
      check("a48_en_count", 64'(en_count), 64'd16);
      matrix_enable = 1'b0;
      step();
      matrix_addr = 12'd0;
      matrix_enable = 1'b1;
      step(); step(); step(); step(); step();

      // Asynchronous reset mid-fetch
      rst_n = 1'b0;
      #1;
      check("arst_ready", 64'(matrix_ready), 64'd0);
      check("arst_data_lo", 64'(matrix_data[63:0]), 64'd0);
      check("arst_data_hi", 64'(matrix_data[255:192]), 64'd0);
      check("arst_en", 64'(sram_en), 64'd0);
      check("arst_addr", 64'(sram_addr), 64'd0);
      step(); step();
      rst_n = 1'b1;
      addr_log.delete(); en_count = 0;
      wait_ready(lat);
      check("post_rst_latency", 64'(lat), 64'd17);
      check("post_rst_en_count", 64'(en_count), 64'd16);
      check("post_rst_lane3", 64'(lane(3)), 64'h0103);
      check("post_rst_lane15", 64'(lane(15)), 64'h010F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
